hex_display_scanner: RTL and testbench
======================================

// Module: hex_display_scanner
// PURPOSE
//  Downstream consumer of syscall_decoder.Hex/Halt. Time-multiplexes the 32-bit Hex value onto
//  an 8-digit common-anode 7-segment display, one nibble per digit. Holds a tear-free shadow copy
//  of the value, updated only at scan-frame boundaries. Blinks the whole display while Halt=1.
// PARAMETERS
//  CLK_DIV       16'd50000  clk cycles per digit slot (>=2)
//  BLINK_FRAMES  8'd64      full 8-digit frames per blink half-period (>=1)
// PORTS
//  clk      in   1   system clock, all state on posedge
//  reset    in   1   asynchronous, active-low; 0 = reset (overrides everything)
//  Hex      in   32  value to show; digit 0 (rightmost) = Hex[3:0], digit 7 = Hex[31:28]
//  Update   in   1   1-cycle strobe: capture Hex for display (tie to syscall_decoder Enable)
//  Halt     in   1   level: CPU halted -> blink display, light dp on digit 0
//  an       out  8   digit enables, active-low, one-hot-zero when lit
//  seg      out  7   segments {g,f,e,d,c,b,a}, active-low
//  dp       out  1   decimal point, active-low
// BEHAVIOUR
//  Reset (reset=0, async): div_cnt=0, digit_idx=0, pend=0, pend_val=0, shadow=0, blink_cnt=0,
//   blank=0; outputs an=8'hFF, seg=7'h7F, dp=1 (all dark). Blanking holds for as long as reset=0.
//  Divider: div_cnt counts 0..CLK_DIV-1 and wraps; tick = (div_cnt==CLK_DIV-1).
//  Scan: on tick, digit_idx <= digit_idx+1 mod 8 (7 -> 0 wrap). frame_end = tick && digit_idx==7.
//  Capture, evaluated each posedge:
//   - Update && !frame_end: pend_val<=Hex, pend<=1 (a later Update overwrites; last one wins).
//   - frame_end: shadow <= Update ? Hex : (pend ? pend_val : shadow); pend<=0.
//   - Update coincident with frame_end goes straight to shadow and is never lost or delayed.
//   - Shadow never changes mid-frame, so all 8 digits always come from the same value.
//  Blink FSM, states SHOW/BLANK:
//   - Halt=0: state=SHOW, blink_cnt=0 (forced synchronously every cycle).
//   - Halt=1: blink_cnt++ on each frame_end. When blink_cnt reaches BLINK_FRAMES-1 at frame_end:
//     toggle SHOW<->BLANK, blink_cnt<=0.
//   - Halt falling: back to SHOW on the next posedge.
//  Output register, 1-cycle latency from digit_idx/shadow/state:
//   - nib = shadow[4*digit_idx +: 4].
//   - SHOW: an = ~(8'b1 << digit_idx); seg = font(nib);
//     dp = (Halt && digit_idx==0) ? 0 : 1.
//   - BLANK: an = 8'hFF, seg = 7'h7F, dp = 1.
//  Font, hex seg values: 0:40 1:79 2:24 3:30 4:19 5:12 6:02 7:78 8:00 9:10 A:08 b:03 C:46 d:21
//   E:06 F:0E.
//  Widths: div_cnt is 16 bits, blink_cnt 8 bits, digit_idx 3 bits; no overflow beyond the wrap
//   points above.
//  Hex changing without Update has no effect on the display.
// TESTING (CLK_DIV=4, BLINK_FRAMES=2)
//  1. Hold reset=0 for 3 cycles, Hex=32'hFFFFFFFF, Update=1
//     -> an=FF, seg=7F, dp=1 throughout; shadow stays 0.
//  2. Release reset, no Update -> digits scan 0..7, each lit for 4 cycles, an=FE,FD,..7F,
//     seg=40 on every digit; digit 7 wraps back to digit 0.
//  3. Update pulse with Hex=32'h89ABCDEF mid-frame -> the current frame still shows 0s; from the
//     next frame digit0..7 show seg=0E,06,21,46,03,08,10,00.
//  4. Two Updates in one frame (32'h11111111, then 32'h22222222) -> next frame shows all 24 and
//     never 79. Update coincident with frame_end (32'h00000005) -> the immediately following
//     frame shows digit0=12.
//  5. Halt=1 -> dp=0 only while an=FE; display alternates 2 frames lit / 2 frames an=FF.
//     Halt=0 during BLANK -> the next cycle is in SHOW.
//  6. Assert reset=0 mid-frame with Halt=1 -> outputs go dark asynchronously (before the next
//     clk edge); after release, scan restarts at digit 0 with shadow=0 in SHOW.

Source files
------------

// File: rtl/hex_display_scanner.sv
`default_nettype none
// ============================================================================
// Module      : hex_display_scanner
// Description : Scans a 32-bit value onto an 8-digit common-anode 7-segment
//               display with a frame-aligned shadow copy and a halt blinker.
// Revision    : 1.0 - initial release
// ============================================================================
module hex_display_scanner #(
  parameter logic [15:0] CLK_DIV      = 16'd50000,
  parameter logic [7:0]  BLINK_FRAMES = 8'd64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] Hex,
  input  logic        Update,
  input  logic        Halt,
  output logic [7:0]  an,
  output logic [6:0]  seg,
  output logic        dp
);

  typedef enum logic [0:0] {
    ST_SHOW  = 1'b0,
    ST_BLANK = 1'b1
  } blink_state_t;

  localparam logic [15:0] c_div_last   = CLK_DIV - 16'd1;
  localparam logic [7:0]  c_blink_last = BLINK_FRAMES - 8'd1;
  localparam logic [7:0]  c_an_dark    = 8'hFF;
  localparam logic [6:0]  c_seg_dark   = 7'h7F;

  logic [15:0]  r_div_cnt;
  logic [2:0]   r_digit_idx;
  logic         r_pend;
  logic [31:0]  r_pend_val;
  logic [31:0]  r_shadow;
  logic [7:0]   r_blink_cnt;
  blink_state_t r_state;
  logic [7:0]   r_an;
  logic [6:0]   r_seg;
  logic         r_dp;

  logic         w_tick;
  logic         w_frame_end;
  logic [3:0]   w_nib;
  blink_state_t w_state_nxt;
  logic [7:0]   w_blink_nxt;
  logic [7:0]   w_an_nxt;
  logic [6:0]   w_seg_nxt;
  logic         w_dp_nxt;

  function automatic logic [6:0] f_font(input logic [3:0] nib);
    logic [6:0] s;
    s = c_seg_dark;
    case (nib)
      4'h0: s = 7'h40;
      4'h1: s = 7'h79;
      4'h2: s = 7'h24;
      4'h3: s = 7'h30;
      4'h4: s = 7'h19;
      4'h5: s = 7'h12;
      4'h6: s = 7'h02;
      4'h7: s = 7'h78;
      4'h8: s = 7'h00;
      4'h9: s = 7'h10;
      4'hA: s = 7'h08;
      4'hB: s = 7'h03;
      4'hC: s = 7'h46;
      4'hD: s = 7'h21;
      4'hE: s = 7'h06;
      4'hF: s = 7'h0E;
    endcase
    return s;
  endfunction

  assign w_tick      = (r_div_cnt == c_div_last);
  assign w_frame_end = w_tick && (r_digit_idx == 3'd7);
  assign w_nib       = r_shadow[{r_digit_idx, 2'b00} +: 4];

  // Slot divider and digit scan.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_div_cnt   <= '0;
      r_digit_idx <= '0;
    end else begin
      r_div_cnt <= w_tick ? 16'd0 : r_div_cnt + 16'd1;
      if (w_tick) r_digit_idx <= r_digit_idx + 3'd1;
    end
  end

  // The shadow only moves at frame_end so a frame is never torn; an Update
  // landing on frame_end bypasses the pending slot entirely.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_pend     <= 1'b0;
      r_pend_val <= '0;
      r_shadow   <= '0;
    end else if (w_frame_end) begin
      r_shadow <= Update ? Hex : (r_pend ? r_pend_val : r_shadow);
      r_pend   <= 1'b0;
    end else if (Update) begin
      r_pend_val <= Hex;
      r_pend     <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= ST_SHOW;
      r_blink_cnt <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_blink_cnt <= w_blink_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_blink_nxt = r_blink_cnt;
    if (!Halt) begin
      w_state_nxt = ST_SHOW;
      w_blink_nxt = '0;
    end else if (w_frame_end) begin
      if (r_blink_cnt == c_blink_last) begin
        w_state_nxt = (r_state == ST_SHOW) ? ST_BLANK : ST_SHOW;
        w_blink_nxt = '0;
      end else begin
        w_blink_nxt = r_blink_cnt + 8'd1;
      end
    end
  end

  always_comb begin
    w_an_nxt  = c_an_dark;
    w_seg_nxt = c_seg_dark;
    w_dp_nxt  = 1'b1;
    if (r_state == ST_SHOW) begin
      w_an_nxt  = ~(8'b1 << r_digit_idx);
      w_seg_nxt = f_font(w_nib);
      w_dp_nxt  = !(Halt && (r_digit_idx == 3'd0));
    end
  end

  // Registered drive keeps the pad outputs glitch-free.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_an  <= c_an_dark;
      r_seg <= c_seg_dark;
      r_dp  <= 1'b1;
    end else begin
      r_an  <= w_an_nxt;
      r_seg <= w_seg_nxt;
      r_dp  <= w_dp_nxt;
    end
  end

  assign an  = r_an;
  assign seg = r_seg;
  assign dp  = r_dp;

endmodule
`default_nettype wire

// File: tb/tb_hex_display_scanner.sv
`default_nettype none
// ============================================================================
// Module      : tb_hex_display_scanner
// Description : Directed scoreboard bench for hex_display_scanner.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_hex_display_scanner;

  localparam logic [15:0] CLK_DIV      = 16'd4;
  localparam logic [7:0]  BLINK_FRAMES = 8'd2;
  localparam int          SLOT         = 4;
  localparam int          FRAME        = 32;
  localparam logic [15:0] c_dark       = {8'hFF, 7'h7F, 1'b1};

  logic        clk    = 1'b0;
  logic        reset  = 1'b0;
  logic [31:0] Hex    = '0;
  logic        Update = 1'b0;
  logic        Halt   = 1'b0;
  logic [7:0]  an;
  logic [6:0]  seg;
  logic        dp;

  hex_display_scanner #(
    .CLK_DIV      (CLK_DIV),
    .BLINK_FRAMES (BLINK_FRAMES)
  ) dut (
    .clk    (clk),
    .reset  (reset),
    .Hex    (Hex),
    .Update (Update),
    .Halt   (Halt),
    .an     (an),
    .seg    (seg),
    .dp     (dp)
  );

  always #5 clk = ~clk;

  logic [6:0] font_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  logic [15:0] sb_q[$];
  int n_checks = 0;
  int n_fail   = 0;

  // Reference state: m_t counts clock edges since reset release.
  int          m_t;
  logic [31:0] m_shadow;
  logic [31:0] m_pendv;
  bit          m_pend;
  bit          m_blank;
  int          m_cnt;

  task automatic model_reset();
    m_t = 0; m_shadow = '0; m_pendv = '0; m_pend = 0; m_blank = 0; m_cnt = 0;
  endtask

  task automatic check(input string tag);
    logic [15:0] obs;
    logic [15:0] exp;
    obs = {an, seg, dp};
    n_checks++;
    assert (sb_q.size() != 0) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=<empty scoreboard>", tag, obs);
      return;
    end
    exp = sb_q.pop_front();
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed an=%h seg=%h dp=%b expected an=%h seg=%h dp=%b",
             tag, obs[15:8], obs[7:1], obs[0], exp[15:8], exp[7:1], exp[0]);
    end
  endtask

  // Predict the output produced by the next edge, advance the model, then
  // compare on the following falling edge.
  task automatic step(input string tag);
    int       idx;
    bit       fe;
    logic [3:0] nib;
    if (!reset) begin
      sb_q.push_back(c_dark);
      model_reset();
    end else begin
      idx = (m_t / SLOT) % 8;
      fe  = (m_t % FRAME) == FRAME - 1;
      nib = m_shadow[4*idx +: 4];
      if (m_blank) sb_q.push_back(c_dark);
      else sb_q.push_back({~(8'h01 << idx), font_tab[nib], !(Halt && idx == 0)});
      if (fe) begin
        m_shadow = Update ? Hex : (m_pend ? m_pendv : m_shadow);
        m_pend   = 0;
      end else if (Update) begin
        m_pendv = Hex;
        m_pend  = 1;
      end
      if (!Halt) begin
        m_blank = 0;
        m_cnt   = 0;
      end else if (fe) begin
        if (m_cnt == BLINK_FRAMES - 1) begin
          m_blank = !m_blank;
          m_cnt   = 0;
        end else begin
          m_cnt++;
        end
      end
      m_t++;
    end
    @(posedge clk);
    @(negedge clk);
    check(tag);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    model_reset();
    // Reset held with Update active: display dark, shadow untouched.
    Hex = 32'hFFFF_FFFF; Update = 1'b1;
    repeat (3) step("reset_hold");

    reset = 1'b1; Update = 1'b0; Hex = '0;
    for (int i = 0; i < 40; i++) begin
      step("scan_zero");
      Hex = $urandom;
    end

    // Mid-frame Update only shows from the next frame.
    Hex = 32'h89AB_CDEF; Update = 1'b1;
    step("upd_midframe");
    Update = 1'b0; Hex = 32'h1234_5678;
    for (int i = 0; i < 60; i++) step("show_89abcdef");

    // Two Updates within one frame: last one wins.
    while ((m_t % FRAME) != 4) step("align_frame");
    Hex = 32'h1111_1111; Update = 1'b1; step("upd_first");
    Update = 1'b0; repeat (5) step("between_upd");
    Hex = 32'h2222_2222; Update = 1'b1; step("upd_second");
    Update = 1'b0;
    for (int i = 0; i < 40; i++) step("show_2222");

    // Update coincident with frame_end goes straight to the shadow.
    while ((m_t % FRAME) != FRAME - 1) step("to_frame_end");
    Hex = 32'h0000_0005; Update = 1'b1; step("upd_frame_end");
    Update = 1'b0;
    for (int i = 0; i < 36; i++) step("show_5");

    // Halt blinking.
    Halt = 1'b1;
    for (int i = 0; i < 5 * FRAME; i++) step("halt_blink");
    for (int i = 0; i < 4 * FRAME && !m_blank; i++) step("to_blank");
    repeat (3) step("in_blank");
    Halt = 1'b0;
    step("halt_drop");
    for (int i = 0; i < 12; i++) step("after_halt");

    // Asynchronous reset mid-frame while halted.
    Halt = 1'b1;
    for (int i = 0; i < 10; i++) step("halt_pre_reset");
    #2 reset = 1'b0;
    #1 sb_q.push_back(c_dark);
    check("async_reset");
    model_reset();
    repeat (2) step("reset_low");
    reset = 1'b1;
    for (int i = 0; i < 40; i++) step("restart_scan");
    Halt = 1'b0;
    repeat (4) step("final");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
